dlx_instr_encoder: RTL and testbench

Streaming DLX instruction encoder and program writer: the inverse of the ID-stage decoder. It accepts mnemonic-level instruction descriptors over a valid/ready handshake, packs each one into a 32-bit DLX word, range-checks the immediate, and writes legal words to consecutive instruction-memory addresses. It is used by the boot loader and the test harness to build programs in instruction memory before the pipeline is released from reset.

---
 rtl/dlx_pkg.sv | 42 ++++
 rtl/dlx_instr_encoder_if.sv | 17 +
 rtl/dlx_encode_word.sv | 82 ++++++++
 rtl/dlx_instr_encoder.sv | 115 +++++++++++
 tb/tb_dlx_instr_encoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX encoding constants: mnemonic codes, opcode/funct values and the
// format/immediate-class enums used by the encoder and the ID-stage decoder.
package dlx_pkg;

  // 33 mnemonics need a 6-bit code; codes 33..63 are undefined and rejected.
  localparam int ENC_OP_W = 6;

  typedef enum logic [ENC_OP_W-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SEQ, OP_SNE, OP_SLT, OP_SLE,
    OP_ADDI, OP_SUBI, OP_SEQI, OP_SNEI, OP_SLTI, OP_SLEI, OP_BEQZ, OP_BNEZ,
    OP_LW, OP_SW,
    OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_LHI, OP_JR, OP_JALR,
    OP_J, OP_JAL
  } enc_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_J    = 6'h02, OPC_JAL  = 6'h03;
  localparam logic [5:0] OPC_BEQZ  = 6'h04, OPC_BNEZ = 6'h05, OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SUBI  = 6'h0A, OPC_ANDI = 6'h0C, OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E, OPC_LHI  = 6'h0F, OPC_JR   = 6'h12;
  localparam logic [5:0] OPC_JALR  = 6'h13, OPC_SLLI = 6'h14, OPC_SRLI = 6'h16;
  localparam logic [5:0] OPC_SRAI  = 6'h17, OPC_SEQI = 6'h18, OPC_SNEI = 6'h19;
  localparam logic [5:0] OPC_SLTI  = 6'h1A, OPC_SLEI = 6'h1C, OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h04, FN_SRL = 6'h06, FN_SRA = 6'h07;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25, FN_XOR = 6'h26, FN_SEQ = 6'h28;
  localparam logic [5:0] FN_SNE = 6'h29, FN_SLT = 6'h2A, FN_SLE = 6'h2C;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;
  typedef enum logic [1:0] {IMM_SIGNED, IMM_UNSIGNED, IMM_JUMP} imm_class_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} enc_state_t;

  // True when bits [31:lsb] are all ones or all zeros, i.e. v sign-extends from bit lsb.
  function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lsb;
    return ((v & m) == m) || ((v & m) == 32'd0);
  endfunction

endpackage

// File: rtl/dlx_instr_encoder_if.sv
// Descriptor channel into the encoder: valid/ready plus mnemonic-level fields.
interface dlx_enc_if;
  import dlx_pkg::*;

  logic                enc_valid;
  logic                enc_ready;
  logic [ENC_OP_W-1:0] enc_op;
  logic [4:0]          enc_rs1;
  logic [4:0]          enc_rs2;
  logic [4:0]          enc_rd;
  logic [31:0]         enc_imm;

  modport master (output enc_valid, enc_op, enc_rs1, enc_rs2, enc_rd, enc_imm,
                  input  enc_ready);
  modport slave  (input  enc_valid, enc_op, enc_rs1, enc_rs2, enc_rd, enc_imm,
                  output enc_ready);
endinterface

// File: rtl/dlx_encode_word.sv
// Combinational packer: mnemonic descriptor -> 32-bit DLX word plus legality
// (known mnemonic and immediate within the range of its format).
module dlx_encode_word
  import dlx_pkg::*;
(
  input  logic [ENC_OP_W-1:0] op_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  input  logic [4:0]          rd_i,
  input  logic [31:0]         imm_i,
  output logic [31:0]         word_o,
  output logic                legal_o
);

  fmt_t       fmt;
  imm_class_t cls;
  logic [5:0] code;
  logic       known;
  logic       use_rs2;
  logic       range_ok;

  always_comb begin
    fmt     = FMT_I;
    cls     = IMM_SIGNED;
    code    = 6'h00;
    known   = 1'b1;
    use_rs2 = 1'b0;
    case (op_i)
      OP_ADD:  begin fmt = FMT_R; code = FN_ADD; end
      OP_SUB:  begin fmt = FMT_R; code = FN_SUB; end
      OP_AND:  begin fmt = FMT_R; code = FN_AND; end
      OP_OR:   begin fmt = FMT_R; code = FN_OR;  end
      OP_XOR:  begin fmt = FMT_R; code = FN_XOR; end
      OP_SLL:  begin fmt = FMT_R; code = FN_SLL; end
      OP_SRL:  begin fmt = FMT_R; code = FN_SRL; end
      OP_SRA:  begin fmt = FMT_R; code = FN_SRA; end
      OP_SEQ:  begin fmt = FMT_R; code = FN_SEQ; end
      OP_SNE:  begin fmt = FMT_R; code = FN_SNE; end
      OP_SLT:  begin fmt = FMT_R; code = FN_SLT; end
      OP_SLE:  begin fmt = FMT_R; code = FN_SLE; end
      OP_ADDI: code = OPC_ADDI;
      OP_SUBI: code = OPC_SUBI;
      OP_SEQI: code = OPC_SEQI;
      OP_SNEI: code = OPC_SNEI;
      OP_SLTI: code = OPC_SLTI;
      OP_SLEI: code = OPC_SLEI;
      OP_BEQZ: code = OPC_BEQZ;
      OP_BNEZ: code = OPC_BNEZ;
      OP_LW:   code = OPC_LW;
      OP_SW:   begin code = OPC_SW; use_rs2 = 1'b1; end
      OP_ANDI: begin cls = IMM_UNSIGNED; code = OPC_ANDI; end
      OP_ORI:  begin cls = IMM_UNSIGNED; code = OPC_ORI;  end
      OP_XORI: begin cls = IMM_UNSIGNED; code = OPC_XORI; end
      OP_SLLI: begin cls = IMM_UNSIGNED; code = OPC_SLLI; end
      OP_SRLI: begin cls = IMM_UNSIGNED; code = OPC_SRLI; end
      OP_SRAI: begin cls = IMM_UNSIGNED; code = OPC_SRAI; end
      OP_LHI:  begin cls = IMM_UNSIGNED; code = OPC_LHI;  end
      OP_JR:   begin cls = IMM_UNSIGNED; code = OPC_JR;   end
      OP_JALR: begin cls = IMM_UNSIGNED; code = OPC_JALR; end
      OP_J:    begin fmt = FMT_J; cls = IMM_JUMP; code = OPC_J;   end
      OP_JAL:  begin fmt = FMT_J; cls = IMM_JUMP; code = OPC_JAL; end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    word_o   = 32'd0;
    range_ok = 1'b0;
    case (fmt)
      FMT_R:   word_o = {OPC_RTYPE, rs1_i, rs2_i, rd_i, 5'd0, code};
      FMT_J:   word_o = {code, imm_i[25:0]};
      default: word_o = {code, rs1_i, (use_rs2 ? rs2_i : rd_i), imm_i[15:0]};
    endcase
    case (cls)
      IMM_SIGNED:   range_ok = upper_uniform(imm_i, 15);
      IMM_UNSIGNED: range_ok = (imm_i[31:16] == 16'd0);
      default:      range_ok = upper_uniform(imm_i, 25);
    endcase
    legal_o = known && ((fmt == FMT_R) || range_ok);
  end

endmodule

// File: rtl/dlx_instr_encoder.sv
// Streaming DLX program writer: accepts descriptors, encodes them and writes
// legal words to consecutive instruction-memory addresses one cycle later.
module dlx_instr_encoder
  import dlx_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              finish,
  dlx_enc_if.slave          enc,
  output logic              i_write_enable,
  output logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_data_write,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   word_count
);

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              err_q, err_d;
  logic [7:0]        errcnt_q, errcnt_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_dat_q, wr_dat_d;

  logic [31:0] word;
  logic        legal;
  logic        accept;

  dlx_encode_word u_encode (
    .op_i   (enc.enc_op),
    .rs1_i  (enc.enc_rs1),
    .rs2_i  (enc.enc_rs2),
    .rd_i   (enc.enc_rd),
    .imm_i  (enc.enc_imm),
    .word_o (word),
    .legal_o(legal)
  );

  // A descriptor is never taken in a start/finish cycle, so control and data never collide.
  assign enc.enc_ready = (state_q == S_RUN) && !start && !finish;
  assign accept        = enc.enc_valid && enc.enc_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wc_d      = wc_q;
    err_d     = err_q;
    errcnt_d  = errcnt_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    if (accept) begin
      if (legal) begin
        wr_vld_d  = 1'b1;
        wr_addr_d = addr_q;
        wr_dat_d  = word;
        addr_d    = addr_q + 1'b1;
        wc_d      = wc_q + 1'b1;
        if (addr_q == {ADDR_W{1'b1}}) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
    end
    if (start) begin
      state_d  = S_RUN;
      addr_d   = start_addr;
      wc_d     = '0;
      err_d    = 1'b0;
      errcnt_d = 8'd0;
    end else if (finish) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wc_q      <= '0;
      err_q     <= 1'b0;
      errcnt_q  <= 8'd0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
      errcnt_q  <= errcnt_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
    end
  end

  assign i_write_enable = wr_vld_q;
  assign i_addr         = wr_addr_q;
  assign i_data_write   = wr_dat_q;
  assign busy           = (state_q == S_RUN);
  assign full           = (state_q == S_FULL);
  assign err            = err_q;
  assign err_count      = errcnt_q;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_dlx_instr_encoder.sv
// Bench for dlx_instr_encoder: directed scenarios plus a randomized stream
// checked against a table-driven reference model.
module tb_dlx_instr_encoder;
  import dlx_pkg::*;

  // Per mnemonic (package order): 0=R, 1=signed I, 2=unsigned I, 3=jump.
  localparam int KIND [0:32] = '{0,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,1,1,
                                 2,2,2,2,2,2,2,2,2, 3,3};
  localparam int CODE [0:32] = '{'h20,'h22,'h24,'h25,'h26,'h04,'h06,'h07,'h28,'h29,'h2A,'h2C,
                                 'h08,'h0A,'h18,'h19,'h1A,'h1C,'h04,'h05,'h23,'h2B,
                                 'h0C,'h0D,'h0E,'h14,'h16,'h17,'h0F,'h12,'h13,
                                 'h02,'h03};
  localparam logic [31:0] BND [0:9] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000,
                                        32'hFFFF_7FFF, 32'h0000_FFFF, 32'h0001_0000,
                                        32'h01FF_FFFF, 32'h0200_0000, 32'hFE00_0000,
                                        32'hFDFF_FFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, finish, s_start, s_finish;
  logic [9:0]  start_addr;
  logic [1:0]  s_start_addr;
  logic        i_write_enable, busy, full, err;
  logic [9:0]  i_addr;
  logic [31:0] i_data_write;
  logic [7:0]  err_count;
  logic [10:0] word_count;
  logic        s_we, s_busy, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  logic [7:0]  s_errcnt;
  logic [2:0]  s_wc;

  dlx_enc_if enc_if ();
  dlx_enc_if s_if ();

  dlx_instr_encoder #(.ADDR_W(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .finish(finish),
    .enc(enc_if), .i_write_enable(i_write_enable), .i_addr(i_addr),
    .i_data_write(i_data_write), .busy(busy), .full(full), .err(err),
    .err_count(err_count), .word_count(word_count));

  dlx_instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .start_addr(s_start_addr), .finish(s_finish),
    .enc(s_if), .i_write_enable(s_we), .i_addr(s_addr),
    .i_data_write(s_data), .busy(s_busy), .full(s_full), .err(s_err),
    .err_count(s_errcnt), .word_count(s_wc));

  int vectors = 0;
  int miscompares = 0;
  int m_mode, m_addr, m_wc, m_err, m_errcnt, m_we, m_waddr;
  logic [31:0] m_wdata;

  // {legal, word} straight from the instruction-format rules.
  function automatic logic [32:0] ref_encode(input int op, input int rs1, input int rs2,
                                             input int rd, input logic [31:0] imm);
    longint s, w;
    logic ok;
    if (op < 0 || op > 32) return 33'd0;
    s  = longint'($signed(imm));
    w  = longint'(CODE[op]) * 67108864;
    ok = 1'b1;
    case (KIND[op])
      0: w = longint'(rs1) * 2097152 + longint'(rs2) * 65536 + longint'(rd) * 2048
             + longint'(CODE[op]);
      1: begin
        ok = (s >= -32768) && (s <= 32767);
        w  = w + longint'(rs1) * 2097152 + longint'(op == 21 ? rs2 : rd) * 65536 + (s & 65535);
      end
      2: begin
        ok = (s >= 0) && (s <= 65535);
        w  = w + longint'(rs1) * 2097152 + longint'(rd) * 65536 + (s & 65535);
      end
      default: begin
        ok = (s >= -33554432) && (s <= 33554431);
        w  = w + (s & 67108863);
      end
    endcase
    return {ok, w[31:0]};
  endfunction

  task automatic model_edge();
    logic [32:0] r;
    if (reset) begin
      m_mode = 0; m_addr = 0; m_wc = 0; m_err = 0; m_errcnt = 0;
      m_we = 0; m_waddr = 0; m_wdata = 32'd0;
      return;
    end
    m_we = 0;
    if (enc_if.enc_valid && m_mode == 1 && !start && !finish) begin
      r = ref_encode(int'(enc_if.enc_op), int'(enc_if.enc_rs1), int'(enc_if.enc_rs2),
                     int'(enc_if.enc_rd), enc_if.enc_imm);
      if (r[32]) begin
        m_we = 1; m_waddr = m_addr; m_wdata = r[31:0]; m_wc++;
        if (m_addr == 1023) m_mode = 2;
        m_addr = (m_addr + 1) % 1024;
      end else begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
    if (start) begin
      m_mode = 1; m_addr = int'(start_addr); m_wc = 0; m_err = 0; m_errcnt = 0;
    end else if (finish) begin
      m_mode = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int op, input int rs1, input int rs2,
                       input int rd, input logic [31:0] imm);
    enc_if.enc_valid = (v != 0);
    enc_if.enc_op    = 6'(op);
    enc_if.enc_rs1   = 5'(rs1);
    enc_if.enc_rs2   = 5'(rs2);
    enc_if.enc_rd    = 5'(rd);
    enc_if.enc_imm   = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if ({i_write_enable, i_addr, i_data_write, busy, full, err, err_count, word_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b full=%b err=%b cnt=%h wc=%h, expected all 0",
               i_write_enable, i_addr, i_data_write, busy, full, err, err_count, word_count);
    end
    vectors++;
    if (enc_if.enc_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 0", enc_if.enc_ready);
    end
    vectors++;
    if ({s_we, s_addr, s_data, s_busy, s_full, s_err, s_errcnt, s_wc, s_if.enc_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_small: got we=%b data=%h busy=%b full=%b wc=%h rdy=%b, expected all 0",
               s_we, s_data, s_busy, s_full, s_wc, s_if.enc_ready);
    end
  endtask

  task automatic test_add();
    start = 1'b1; start_addr = 10'd0;
    tick();
    start = 1'b0;
    drive(1, int'(OP_ADD), 1, 2, 3, 32'd0);
    #1;
    vectors++;
    if (enc_if.enc_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ready: got rdy=%b busy=%b expected 1 1", enc_if.enc_ready, busy);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    vectors++;
    if ({i_write_enable, i_addr, i_data_write, word_count} !== {1'b1, 10'd0, 32'h0022_1820, 11'd1}) begin
      miscompares++;
      $display("FAIL add_write: got we=%b addr=%h data=%h wc=%0d expected 1 000 00221820 1",
               i_write_enable, i_addr, i_data_write, word_count);
    end
  endtask

  task automatic test_back_to_back();
    logic r0, r1;
    drive(1, int'(OP_ADDI), 0, 0, 5, 32'hFFFF_FFFF);
    #1 r0 = enc_if.enc_ready;
    tick();
    vectors++;
    if ({i_write_enable, i_addr, i_data_write} !== {1'b1, 10'd1, 32'h2005_FFFF}) begin
      miscompares++;
      $display("FAIL b2b_addi: got we=%b addr=%h data=%h expected 1 001 2005ffff",
               i_write_enable, i_addr, i_data_write);
    end
    drive(1, int'(OP_JAL), 0, 0, 0, 32'h10);
    #1 r1 = enc_if.enc_ready;
    tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    vectors++;
    if ({i_write_enable, i_addr, i_data_write} !== {1'b1, 10'd2, 32'h0C00_0010}) begin
      miscompares++;
      $display("FAIL b2b_jal: got we=%b addr=%h data=%h expected 1 002 0c000010",
               i_write_enable, i_addr, i_data_write);
    end
    vectors++;
    if ({r0, r1} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b%b expected 11", r0, r1);
    end
  endtask

  task automatic test_illegal();
    drive(1, int'(OP_ORI), 1, 0, 2, 32'h0001_0000);
    tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    vectors++;
    if ({i_write_enable, err, err_count, word_count} !== {1'b0, 1'b1, 8'd1, 11'd3}) begin
      miscompares++;
      $display("FAIL illegal_ori: got we=%b err=%b cnt=%0d wc=%0d expected 0 1 1 3",
               i_write_enable, err, err_count, word_count);
    end
    drive(1, int'(OP_SW), 4, 6, 9, 32'd8);
    tick();
    vectors++;
    if ({i_write_enable, i_addr, i_data_write} !== {1'b1, 10'd3, 32'hAC86_0008}) begin
      miscompares++;
      $display("FAIL illegal_sw: got we=%b addr=%h data=%h expected 1 003 ac860008",
               i_write_enable, i_addr, i_data_write);
    end
    drive(1, 45, 1, 1, 1, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    vectors++;
    if ({i_write_enable, err_count, word_count} !== {1'b0, 8'd2, 11'd4}) begin
      miscompares++;
      $display("FAIL illegal_undef: got we=%b cnt=%0d wc=%0d expected 0 2 4",
               i_write_enable, err_count, word_count);
    end
  endtask

  task automatic test_start_inflight();
    drive(1, int'(OP_SUB), 7, 8, 9, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    start = 1'b1; start_addr = 10'd8;
    vectors++;
    if ({i_write_enable, i_addr, word_count} !== {1'b1, 10'd4, 11'd5}) begin
      miscompares++;
      $display("FAIL inflight_write: got we=%b addr=%h wc=%0d expected 1 004 5",
               i_write_enable, i_addr, word_count);
    end
    tick();
    start = 1'b0;
    vectors++;
    if ({i_write_enable, busy, err, err_count, word_count} !== {1'b0, 1'b1, 1'b0, 8'd0, 11'd0}) begin
      miscompares++;
      $display("FAIL inflight_clear: got we=%b busy=%b err=%b cnt=%0d wc=%0d expected 0 1 0 0 0",
               i_write_enable, busy, err, err_count, word_count);
    end
    drive(1, int'(OP_ADD), 1, 2, 3, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    vectors++;
    if ({i_write_enable, i_addr, word_count} !== {1'b1, 10'd8, 11'd1}) begin
      miscompares++;
      $display("FAIL inflight_next: got we=%b addr=%h wc=%0d expected 1 008 1",
               i_write_enable, i_addr, word_count);
    end
  endtask

  task automatic test_saturate();
    drive(1, 50, 0, 0, 0, 32'd0);
    for (int i = 0; i < 260; i++) tick();
    drive(0, 0, 0, 0, 0, 32'd0);
    vectors++;
    if ({err, err_count, word_count} !== {1'b1, 8'd255, 11'd1}) begin
      miscompares++;
      $display("FAIL saturate: got err=%b cnt=%0d wc=%0d expected 1 255 1", err, err_count, word_count);
    end
  endtask

  task automatic test_small_full();
    logic        rdy;
    logic [32:0] r;
    s_start = 1'b1; s_start_addr = 2'd2;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.enc_valid = 1'b1; s_if.enc_op = 6'(OP_ADDI);
      s_if.enc_rs1 = 5'(i + 1); s_if.enc_rs2 = 5'd0; s_if.enc_rd = 5'(i + 4);
      s_if.enc_imm = 32'(i * 3);
      r = ref_encode(int'(OP_ADDI), i + 1, 0, i + 4, 32'(i * 3));
      #1 rdy = s_if.enc_ready;
      vectors++;
      if (rdy !== (i < 2)) begin
        miscompares++;
        $display("FAIL small_ready%0d: got %b expected %b", i, rdy, (i < 2));
      end
      tick();
      vectors++;
      if (i < 2 && {s_we, s_addr, s_data} !== {1'b1, 2'(i + 2), r[31:0]}) begin
        miscompares++;
        $display("FAIL small_write%0d: got we=%b addr=%0d data=%h expected 1 %0d %h",
                 i, s_we, s_addr, s_data, i + 2, r[31:0]);
      end else if (i == 2 && {s_we, s_full, s_busy, s_wc} !== {1'b0, 1'b1, 1'b0, 3'd2}) begin
        miscompares++;
        $display("FAIL small_full: got we=%b full=%b busy=%b wc=%0d expected 0 1 0 2",
                 s_we, s_full, s_busy, s_wc);
      end
    end
    vectors++;
    if ({s_full, s_if.enc_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL small_hold: got full=%b rdy=%b expected 1 0", s_full, s_if.enc_ready);
    end
    s_if.enc_valid = 1'b0;
    s_finish = 1'b1;
    tick();
    s_finish = 1'b0;
    vectors++;
    if ({s_full, s_busy, s_we} !== 3'b000) begin
      miscompares++;
      $display("FAIL small_finish: got full=%b busy=%b we=%b expected 0 0 0", s_full, s_busy, s_we);
    end
  endtask

  task automatic test_random();
    logic [31:0] imm;
    logic        exp_rdy;
    logic [21:0] exp_st;
    for (int n = 0; n < 1500; n++) begin
      start  = ($urandom_range(0, 63) == 0) || (n == 0);
      finish = ($urandom_range(0, 99) == 0);
      start_addr = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(1008, 1023))
                                                : 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 5))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 65535));
        2: imm = BND[$urandom_range(0, 9)];
        3: imm = 32'(-int'($urandom_range(0, 40000)));
        4: imm = $urandom & 32'h03FF_FFFF;
        default: imm = 32'($signed($urandom & 32'h03FF_FFFF) <<< 6) >>> 6;
      endcase
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 40), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), imm);
      exp_rdy = (m_mode == 1) && !start && !finish;
      #1;
      vectors++;
      if (enc_if.enc_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_ready@%0d: got %b expected %b", n, enc_if.enc_ready, exp_rdy);
      end
      tick();
      vectors++;
      if (i_write_enable !== 1'(m_we)) begin
        miscompares++;
        $display("FAIL rand_we@%0d: got %b expected %0d", n, i_write_enable, m_we);
      end else if (m_we == 1 && {i_addr, i_data_write} !== {10'(m_waddr), m_wdata}) begin
        miscompares++;
        $display("FAIL rand_write@%0d: got addr=%h data=%h expected %h %h",
                 n, i_addr, i_data_write, 10'(m_waddr), m_wdata);
      end
      exp_st = {m_mode == 1, m_mode == 2, m_err != 0, 8'(m_errcnt), 11'(m_wc)};
      vectors++;
      if ({busy, full, err, err_count, word_count} !== exp_st) begin
        miscompares++;
        $display("FAIL rand_status@%0d: got busy=%b full=%b err=%b cnt=%0d wc=%0d expected %b",
                 n, busy, full, err, err_count, word_count, exp_st);
      end
    end
    start = 1'b0; finish = 1'b0;
    drive(0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic test_reset_midstream();
    start = 1'b1; start_addr = 10'd100;
    tick();
    start = 1'b0;
    drive(1, int'(OP_XOR), 3, 4, 5, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({i_write_enable, i_addr, i_data_write, busy, full, err, err_count, word_count} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got we=%b addr=%h data=%h busy=%b wc=%0d expected all 0",
               i_write_enable, i_addr, i_data_write, busy, word_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({i_write_enable, busy, enc_if.enc_ready} !== 3'b000) begin
        miscompares++;
        $display("FAIL midreset_idle%0d: got we=%b busy=%b rdy=%b expected 0 0 0",
                 i, i_write_enable, busy, enc_if.enc_ready);
      end
    end
    drive(0, 0, 0, 0, 0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; start_addr = 10'd0;
    s_start = 1'b0; s_finish = 1'b0; s_start_addr = 2'd0;
    drive(0, 0, 0, 0, 0, 32'd0);
    s_if.enc_valid = 1'b0; s_if.enc_op = 6'd0; s_if.enc_rs1 = 5'd0;
    s_if.enc_rs2 = 5'd0; s_if.enc_rd = 5'd0; s_if.enc_imm = 32'd0;
    m_mode = 0; m_addr = 0; m_wc = 0; m_err = 0; m_errcnt = 0; m_we = 0; m_waddr = 0;
    m_wdata = 32'd0;
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_start_inflight();
    test_saturate();
    test_small_full();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
